// File: rtl/alu_decode_stage.sv
// RV32I decode stage: instruction -> ALU control word and operand selects.
// One output register plus one skid register keep full throughput with a registered in_ready.
module alu_decode_stage #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instr,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       alu_control,
    output logic             use_imm,
    output logic [31:0]      imm,
    output logic [4:0]       rs1,
    output logic [4:0]       rs2,
    output logic [4:0]       rd,
    output logic             illegal,
    output logic [CNT_W-1:0] illegal_count
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [3:0] ALU_SLL = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0100;
    localparam logic [3:0] ALU_SLT = 4'b0101;
    localparam logic [3:0] ALU_XOR = 4'b0110;

    typedef struct packed {
        logic [3:0]  alu_control;
        logic        use_imm;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        illegal;
    } dec_t;

    logic [6:0]       opcode;
    logic [2:0]       f3;
    logic [6:0]       f7;
    logic [31:0]      imm_i;
    logic [31:0]      imm_s;
    logic             bad_c;
    dec_t             dec_c;
    dec_t             out_q;
    dec_t             skid_q;
    logic             out_valid_q;
    logic             skid_valid_q;
    logic             in_ready_q;
    logic [CNT_W-1:0] cnt_q;
    logic             accept_c;
    logic             load_out_c;

    assign opcode = instr[6:0];
    assign f3     = instr[14:12];
    assign f7     = instr[31:25];
    assign imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};

    // Combinational decode; illegal encodings collapse to a zeroed control word.
    always_comb begin
        dec_c     = '0;
        dec_c.rs1 = instr[19:15];
        dec_c.rs2 = instr[24:20];
        dec_c.rd  = instr[11:7];
        bad_c     = 1'b0;
        unique case (opcode)
            OP_R: begin
                unique case (f3)
                    3'b000: begin
                        if (f7 == 7'b0000000)      dec_c.alu_control = ALU_ADD;
                        else if (f7 == 7'b0100000) dec_c.alu_control = ALU_SUB;
                        else                       bad_c = 1'b1;
                    end
                    3'b001:  if (f7 == 7'd0) dec_c.alu_control = ALU_SLL; else bad_c = 1'b1;
                    3'b010:  if (f7 == 7'd0) dec_c.alu_control = ALU_SLT; else bad_c = 1'b1;
                    3'b100:  if (f7 == 7'd0) dec_c.alu_control = ALU_XOR; else bad_c = 1'b1;
                    default: bad_c = 1'b1;
                endcase
            end
            OP_I: begin
                dec_c.use_imm = 1'b1;
                dec_c.imm     = imm_i;
                unique case (f3)
                    3'b000: dec_c.alu_control = ALU_ADD;
                    3'b010: dec_c.alu_control = ALU_SLT;
                    3'b100: dec_c.alu_control = ALU_XOR;
                    3'b001: begin
                        dec_c.alu_control = ALU_SLL;
                        dec_c.imm         = {27'd0, instr[24:20]};
                        if (f7 != 7'd0) bad_c = 1'b1;
                    end
                    default: bad_c = 1'b1;
                endcase
            end
            OP_LOAD: begin
                dec_c.alu_control = ALU_ADD;
                dec_c.use_imm     = 1'b1;
                dec_c.imm         = imm_i;
            end
            OP_STORE: begin
                dec_c.alu_control = ALU_ADD;
                dec_c.use_imm     = 1'b1;
                dec_c.imm         = imm_s;
            end
            OP_BRANCH: dec_c.alu_control = ALU_SUB;
            default:   bad_c = 1'b1;
        endcase
        if (bad_c) begin
            dec_c.alu_control = 4'd0;
            dec_c.use_imm     = 1'b0;
            dec_c.imm         = 32'd0;
            dec_c.illegal     = 1'b1;
        end
    end

    assign accept_c   = in_valid & in_ready_q;
    assign load_out_c = ~out_valid_q | out_ready;

    // Output register refills from skid first, otherwise from the decoder.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q        <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
            cnt_q        <= '0;
        end else begin
            if (load_out_c) begin
                if (skid_valid_q) begin
                    out_q        <= skid_q;
                    out_valid_q  <= 1'b1;
                    skid_valid_q <= 1'b0;
                    in_ready_q   <= 1'b1;
                end else if (accept_c) begin
                    out_q       <= dec_c;
                    out_valid_q <= 1'b1;
                end else begin
                    out_valid_q <= 1'b0;
                end
            end else if (accept_c) begin
                skid_q       <= dec_c;
                skid_valid_q <= 1'b1;
                in_ready_q   <= 1'b0;
            end
            if (accept_c && dec_c.illegal && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign in_ready      = in_ready_q;
    assign out_valid     = out_valid_q;
    assign alu_control   = out_q.alu_control;
    assign use_imm       = out_q.use_imm;
    assign imm           = out_q.imm;
    assign rs1           = out_q.rs1;
    assign rs2           = out_q.rs2;
    assign rd            = out_q.rd;
    assign illegal       = out_q.illegal;
    assign illegal_count = cnt_q;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Bench for alu_decode_stage: directed table, backpressure/reset sequences, random traffic vs a queue model.
module tb_alu_decode_stage;

    localparam int CNT_MAX = 255;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        in_valid;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  alu_control;
    logic        use_imm;
    logic [31:0] imm;
    logic [4:0]  rs1, rs2, rd;
    logic        illegal;
    logic [7:0]  illegal_count;

    alu_decode_stage dut (
        .clk(clk), .rst(rst), .instr(instr), .in_valid(in_valid), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .alu_control(alu_control),
        .use_imm(use_imm), .imm(imm), .rs1(rs1), .rs2(rs2), .rd(rd),
        .illegal(illegal), .illegal_count(illegal_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  alu;
        logic        ui;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        ill;
    } ent_t;

    typedef struct {
        logic [31:0] ins;
        ent_t        exp;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    ent_t q[$];
    int   exp_cnt = 0;

    function automatic ent_t dut_ent();
        ent_t e;
        e = {alu_control, use_imm, imm, rs1, rs2, rd, illegal};
        return e;
    endfunction

    // Reference decode: pick an operation number, then fill the word.
    function automatic ent_t model(input logic [31:0] i);
        ent_t       e;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        int         alu;
        logic [31:0] im;
        bit         ui;
        op = i[6:0]; f3 = i[14:12]; f7 = i[31:25];
        alu = -1; im = 32'd0; ui = 1'b0;
        e = '0;
        e.rs1 = i[19:15]; e.rs2 = i[24:20]; e.rd = i[11:7];
        if (op == 7'h33) begin
            if (f7 == 7'h00 && f3 == 3'd0) alu = 2;
            if (f7 == 7'h20 && f3 == 3'd0) alu = 4;
            if (f7 == 7'h00 && f3 == 3'd1) alu = 1;
            if (f7 == 7'h00 && f3 == 3'd2) alu = 5;
            if (f7 == 7'h00 && f3 == 3'd4) alu = 6;
        end else if (op == 7'h13) begin
            ui = 1'b1;
            im = 32'($signed(i[31:20]));
            if (f3 == 3'd0) alu = 2;
            if (f3 == 3'd2) alu = 5;
            if (f3 == 3'd4) alu = 6;
            if (f3 == 3'd1 && f7 == 7'h00) begin alu = 1; im = 32'(i[24:20]); end
        end else if (op == 7'h03) begin
            alu = 2; ui = 1'b1; im = 32'($signed(i[31:20]));
        end else if (op == 7'h23) begin
            alu = 2; ui = 1'b1; im = 32'($signed({i[31:25], i[11:7]}));
        end else if (op == 7'h63) begin
            alu = 4;
        end
        if (alu < 0) e.ill = 1'b1;
        else begin e.alu = 4'(alu); e.ui = ui; e.imm = im; end
        return e;
    endfunction

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_state();
        cmp("in_ready", 64'(in_ready), 64'(q.size() < 2));
        cmp("out_valid", 64'(out_valid), 64'(q.size() > 0));
        cmp("illegal_count", 64'(illegal_count), 64'(exp_cnt));
        if (q.size() > 0) cmp("payload", 64'(dut_ent()), 64'(q[0]));
    endtask

    // One cycle: drive at negedge, update model at posedge, check at next negedge.
    task automatic step(input logic v, input logic [31:0] ins, input logic ordy);
        bit   acc, drn;
        ent_t e;
        in_valid = v; instr = ins; out_ready = ordy;
        acc = v && (q.size() < 2);
        drn = ordy && (q.size() > 0);
        @(posedge clk);
        if (drn) void'(q.pop_front());
        if (acc) begin
            e = model(ins);
            q.push_back(e);
            if (e.ill && exp_cnt < CNT_MAX) exp_cnt++;
        end
        @(negedge clk);
        check_state();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] i;
        logic [6:0]  ops [5];
        int          k;
        ops[0] = 7'h33; ops[1] = 7'h13; ops[2] = 7'h03; ops[3] = 7'h23; ops[4] = 7'h63;
        i = $urandom;
        k = $urandom_range(0, 5);
        if (k < 5) i[6:0] = ops[k];
        k = $urandom_range(0, 2);
        if (k == 0) i[31:25] = 7'h00;
        if (k == 1) i[31:25] = 7'h20;
        return i;
    endfunction

    vec_t tbl[11];

    initial begin
        //        ins            alu   ui  imm            rs1 rs2 rd  ill
        tbl[0]  = '{32'h002081B3, '{4'h2, 0, 32'h00000000, 1,  2,  3,  0}};
        tbl[1]  = '{32'h402081B3, '{4'h4, 0, 32'h00000000, 1,  2,  3,  0}};
        tbl[2]  = '{32'hFFF00093, '{4'h2, 1, 32'hFFFFFFFF, 0,  31, 1,  0}};
        tbl[3]  = '{32'h00329293, '{4'h1, 1, 32'h00000003, 5,  3,  5,  0}};
        tbl[4]  = '{32'h0020A423, '{4'h2, 1, 32'h00000008, 1,  2,  8,  0}};
        tbl[5]  = '{32'h00000000, '{4'h0, 0, 32'h00000000, 0,  0,  0,  1}};
        tbl[6]  = '{32'h00208063, '{4'h4, 0, 32'h00000000, 1,  2,  0,  0}};
        tbl[7]  = '{32'h0020C1B3, '{4'h6, 0, 32'h00000000, 1,  2,  3,  0}};
        tbl[8]  = '{32'hFFC0A283, '{4'h2, 1, 32'hFFFFFFFC, 1,  28, 5,  0}};
        tbl[9]  = '{32'h802081B3, '{4'h0, 0, 32'h00000000, 1,  2,  3,  1}};
        tbl[10] = '{32'h40329293, '{4'h0, 0, 32'h00000000, 5,  3,  5,  1}};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; instr = 32'd0;
        repeat (2) @(negedge clk);
        cmp("rst_out_valid", 64'(out_valid), 64'd0);
        cmp("rst_in_ready", 64'(in_ready), 64'd1);
        cmp("rst_count", 64'(illegal_count), 64'd0);
        cmp("rst_data", 64'(dut_ent()), 64'd0);
        rst = 1'b0;

        // Directed vectors streamed back-to-back, each compared to its hand-derived word.
        for (int k = 0; k < 11; k++) begin
            step(1'b1, tbl[k].ins, 1'b1);
            cmp($sformatf("tbl%0d", k), 64'(dut_ent()), 64'(tbl[k].exp));
            cmp($sformatf("tbl%0d_rdy", k), 64'(in_ready), 64'd1);
        end
        step(1'b0, 32'd0, 1'b1);

        // Backpressure: A held, B parked in skid, C refused until space returns.
        step(1'b1, 32'h002081B3, 1'b0);
        step(1'b1, 32'h402081B3, 1'b0);
        cmp("bp_in_ready_low", 64'(in_ready), 64'd0);
        step(1'b1, 32'h0020C1B3, 1'b0);
        step(1'b1, 32'h0020C1B3, 1'b0);
        cmp("bp_hold_a", 64'(alu_control), 64'h2);
        step(1'b0, 32'd0, 1'b1);
        cmp("bp_then_b", 64'(alu_control), 64'h4);
        cmp("bp_ready_back", 64'(in_ready), 64'd1);
        step(1'b0, 32'd0, 1'b1);
        step(1'b0, 32'd0, 1'b1);

        // Saturation of the illegal counter.
        for (int k = 0; k < 300; k++) step(1'b1, 32'h00000000, 1'b1);
        cmp("count_sat", 64'(illegal_count), 64'd255);
        step(1'b0, 32'd0, 1'b1);

        // Asynchronous reset with both registers occupied.
        step(1'b1, 32'h002081B3, 1'b0);
        step(1'b1, 32'h402081B3, 1'b0);
        #2 rst = 1'b1;
        #1;
        cmp("mid_rst_out_valid", 64'(out_valid), 64'd0);
        cmp("mid_rst_in_ready", 64'(in_ready), 64'd1);
        cmp("mid_rst_count", 64'(illegal_count), 64'd0);
        q.delete();
        exp_cnt = 0;
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 32'h0020C1B3, 1'b1);
        cmp("post_rst_xor", 64'(alu_control), 64'h6);
        step(1'b0, 32'd0, 1'b1);

        // Random traffic with random backpressure.
        for (int k = 0; k < 600; k++) begin
            step(1'($urandom_range(0, 3) != 0), rand_instr(), 1'($urandom_range(0, 3) != 0));
        end
        for (int k = 0; k < 3; k++) step(1'b0, 32'd0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
